// File: rtl/tlp_tx_arbiter.sv
// tlp_tx_arbiter: per-packet fixed-priority / round-robin merge of NUM_CH TLP sources onto one AXI4-Stream TX port
module tlp_tx_arbiter #(
   parameter int          C_DATA_WIDTH = 64,
   parameter int          KEEP_WIDTH   = C_DATA_WIDTH/8,
   parameter int          TUSER_WIDTH  = 4,
   parameter int          NUM_CH       = 3,
   parameter int          ARB_MODE     = 1,
   parameter logic [15:0] STALL_LIMIT  = 16'd1024
) (
   input  logic                             pcie_clk,
   input  logic                             pcie_rst,
   input  logic [NUM_CH-1:0]                s_tx_req,
   output logic [NUM_CH-1:0]                s_tx_ack,
   input  logic [NUM_CH-1:0]                s_tx_tvalid,
   output logic [NUM_CH-1:0]                s_tx_tready,
   input  logic [NUM_CH-1:0]                s_tx_tlast,
   input  logic [NUM_CH*KEEP_WIDTH-1:0]     s_tx_tkeep,
   input  logic [NUM_CH*C_DATA_WIDTH-1:0]   s_tx_tdata,
   input  logic [NUM_CH*TUSER_WIDTH-1:0]    s_tx_tuser,
   input  logic                             m_tx_tready,
   output logic                             m_tx_tvalid,
   output logic                             m_tx_tlast,
   output logic [KEEP_WIDTH-1:0]            m_tx_tkeep,
   output logic [C_DATA_WIDTH-1:0]          m_tx_tdata,
   output logic [TUSER_WIDTH-1:0]           m_tx_tuser,
   output logic [$clog2(NUM_CH)-1:0]        grant_ch,
   output logic                             busy,
   output logic [NUM_CH*32-1:0]             pkt_cnt,
   output logic                             stall_err
);
   localparam int CW = $clog2(NUM_CH);
   typedef enum logic {IDLE, GRANT} state_t;
   state_t state, state_nxt;
   logic [CW-1:0] ptr, win, idx;
   logic [CW:0] sum;
   logic found, xfer;
   logic [15:0] wd, wd_nxt;

   always_ff @(posedge pcie_clk)
      if (pcie_rst) state <= IDLE;
      else state <= state_nxt;

   // search starts at ptr in round-robin mode, at channel 0 in fixed mode
   always_comb begin
      win = '0;
      found = 1'b0;
      sum = '0;
      idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         sum = (ARB_MODE != 0) ? {1'b0, ptr} + (CW+1)'(i) : (CW+1)'(i);
         idx = (sum >= (CW+1)'(NUM_CH)) ? CW'(sum - (CW+1)'(NUM_CH)) : CW'(sum);
         if (!found && s_tx_req[idx]) begin
            found = 1'b1;
            win = idx;
         end
      end
   end

   assign xfer = m_tx_tvalid & m_tx_tready;

   always_comb
      state_nxt = (state == IDLE) ? (found ? GRANT : IDLE) : ((xfer && m_tx_tlast) ? IDLE : GRANT);

   always_comb begin
      busy        = state == GRANT;
      s_tx_ack    = busy ? NUM_CH'(1) << grant_ch : '0;
      s_tx_tready = busy ? NUM_CH'(m_tx_tready) << grant_ch : '0;
      m_tx_tvalid = busy & s_tx_tvalid[grant_ch];
      m_tx_tlast  = busy & s_tx_tlast[grant_ch];
      m_tx_tkeep  = busy ? s_tx_tkeep[grant_ch*KEEP_WIDTH +: KEEP_WIDTH] : '0;
      m_tx_tdata  = busy ? s_tx_tdata[grant_ch*C_DATA_WIDTH +: C_DATA_WIDTH] : '0;
      m_tx_tuser  = busy ? s_tx_tuser[grant_ch*TUSER_WIDTH +: TUSER_WIDTH] : '0;
   end

   // watchdog counts only source-side starvation; backpressure holds it
   assign wd_nxt = (!busy || xfer) ? '0 : (!s_tx_tvalid[grant_ch] && wd != '1) ? wd + 16'd1 : wd;

   always_ff @(posedge pcie_clk)
      if (pcie_rst) begin
         grant_ch  <= '0;
         ptr       <= '0;
         pkt_cnt   <= '0;
         wd        <= '0;
         stall_err <= 1'b0;
      end else begin
         if (state == IDLE && found) grant_ch <= win;
         if (xfer && m_tx_tlast) begin
            ptr <= (grant_ch == CW'(NUM_CH-1)) ? '0 : grant_ch + CW'(1);
            pkt_cnt[grant_ch*32 +: 32] <= pkt_cnt[grant_ch*32 +: 32] + 32'd1;
         end
         wd        <= wd_nxt;
         stall_err <= stall_err | (busy && !s_tx_tvalid[grant_ch] && wd_nxt == STALL_LIMIT);
      end
endmodule

// File: tb/tb_tlp_tx_arbiter.sv
// tb_tlp_tx_arbiter: directed checks of a fixed-priority and a round-robin arbiter driven by shared stimulus
module tb_tlp_tx_arbiter;
   localparam int N = 3, DW = 64, KW = 8, UW = 4;
   logic pcie_clk = 1'b0, pcie_rst = 1'b1, m_tready = 1'b0;
   logic [N-1:0] req = '0, tvalid = '0, tlast = '0;
   logic [N*KW-1:0] tkeep = '0;
   logic [N*DW-1:0] tdata = '0;
   logic [N*UW-1:0] tuser = '0;
   logic [N-1:0] f_ack, f_tready, r_ack, r_tready;
   logic f_tvalid, f_tlast, f_busy, f_stall, r_tvalid, r_tlast, r_busy, r_stall;
   logic [KW-1:0] f_tkeep, r_tkeep;
   logic [DW-1:0] f_tdata, r_tdata;
   logic [UW-1:0] f_tuser, r_tuser;
   logic [1:0] f_gch, r_gch;
   logic [N*32-1:0] f_cnt, r_cnt;
   logic [5:0] pat = 6'b111001;
   int n_chk = 0, n_err = 0, bi;

   always #5 pcie_clk = ~pcie_clk;

   tlp_tx_arbiter #(.C_DATA_WIDTH(DW), .TUSER_WIDTH(UW), .NUM_CH(N), .ARB_MODE(0), .STALL_LIMIT(16'd8)) u_fix (
      .pcie_clk(pcie_clk), .pcie_rst(pcie_rst), .s_tx_req(req), .s_tx_ack(f_ack),
      .s_tx_tvalid(tvalid), .s_tx_tready(f_tready), .s_tx_tlast(tlast), .s_tx_tkeep(tkeep),
      .s_tx_tdata(tdata), .s_tx_tuser(tuser), .m_tx_tready(m_tready), .m_tx_tvalid(f_tvalid),
      .m_tx_tlast(f_tlast), .m_tx_tkeep(f_tkeep), .m_tx_tdata(f_tdata), .m_tx_tuser(f_tuser),
      .grant_ch(f_gch), .busy(f_busy), .pkt_cnt(f_cnt), .stall_err(f_stall));

   tlp_tx_arbiter #(.C_DATA_WIDTH(DW), .TUSER_WIDTH(UW), .NUM_CH(N), .ARB_MODE(1), .STALL_LIMIT(16'd8)) u_rr (
      .pcie_clk(pcie_clk), .pcie_rst(pcie_rst), .s_tx_req(req), .s_tx_ack(r_ack),
      .s_tx_tvalid(tvalid), .s_tx_tready(r_tready), .s_tx_tlast(tlast), .s_tx_tkeep(tkeep),
      .s_tx_tdata(tdata), .s_tx_tuser(tuser), .m_tx_tready(m_tready), .m_tx_tvalid(r_tvalid),
      .m_tx_tlast(r_tlast), .m_tx_tkeep(r_tkeep), .m_tx_tdata(r_tdata), .m_tx_tuser(r_tuser),
      .grant_ch(r_gch), .busy(r_busy), .pkt_cnt(r_cnt), .stall_err(r_stall));

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge pcie_clk);
      #1;
   endtask

   task automatic beat(input int ch, input logic v, input logic l, input logic [63:0] d);
      tvalid[ch] = v;
      tlast[ch] = l;
      tdata[ch*DW +: DW] = d;
      tkeep[ch*KW +: KW] = l ? 8'h0F : 8'hFF;
      tuser[ch*UW +: UW] = d[3:0];
   endtask

   task automatic do_reset;
      pcie_rst = 1'b1;
      req = '0;
      tvalid = '0;
      tlast = '0;
      tick;
      pcie_rst = 1'b0;
   endtask

   initial begin
      m_tready = 1'b1;
      do_reset;
      check("rst_ack", 128'(f_ack), 128'(3'b000));
      check("rst_busy", 128'(f_busy), 128'(1'b0));
      check("rst_tvalid", 128'(f_tvalid), 128'(1'b0));
      check("rst_tdata", 128'(f_tdata), 128'(64'h0));
      check("rst_tready", 128'(f_tready), 128'(3'b000));
      check("rst_gch", 128'(f_gch), 128'(2'd0));
      check("rst_cnt", 128'(f_cnt), 128'(96'h0));
      check("rst_stall", 128'(f_stall), 128'(1'b0));

      // fixed priority: ch1 beats ch2, then ch2 single-beat after one bubble
      req = 3'b110;
      beat(1, 1'b1, 1'b0, 64'h1111_0000_0000_0001);
      beat(2, 1'b1, 1'b1, 64'h2222_0000_0000_0007);
      #1 check("fx_idle_ack", 128'(f_ack), 128'(3'b000));
      tick;
      check("fx_ack1", 128'(f_ack), 128'(3'b010));
      check("fx_gch1", 128'(f_gch), 128'(2'd1));
      check("fx_busy", 128'(f_busy), 128'(1'b1));
      check("fx_d0", 128'(f_tdata), 128'(64'h1111_0000_0000_0001));
      check("fx_tready", 128'(f_tready), 128'(3'b010));
      check("fx_keep0", 128'(f_tkeep), 128'(8'hFF));
      req = 3'b100;
      tick;
      beat(1, 1'b1, 1'b0, 64'h1111_0000_0000_0002);
      #1 check("fx_d1", 128'(f_tdata), 128'(64'h1111_0000_0000_0002));
      check("fx_req_drop_ack", 128'(f_ack), 128'(3'b010));
      tick;
      beat(1, 1'b1, 1'b1, 64'h1111_0000_0000_0003);
      #1 check("fx_d2", 128'(f_tdata), 128'(64'h1111_0000_0000_0003));
      check("fx_last", 128'(f_tlast), 128'(1'b1));
      check("fx_keep2", 128'(f_tkeep), 128'(8'h0F));
      check("fx_user2", 128'(f_tuser), 128'(4'h3));
      tick;
      beat(1, 1'b0, 1'b0, 64'h0);
      check("fx_bubble_busy", 128'(f_busy), 128'(1'b0));
      check("fx_bubble_ack", 128'(f_ack), 128'(3'b000));
      check("fx_cnt1", 128'(f_cnt), 128'({32'd0, 32'd1, 32'd0}));
      tick;
      check("fx_ack2", 128'(f_ack), 128'(3'b100));
      check("fx_d_ch2", 128'(f_tdata), 128'(64'h2222_0000_0000_0007));
      check("fx_last_ch2", 128'(f_tlast), 128'(1'b1));
      req = 3'b000;
      tick;
      check("single_busy", 128'(f_busy), 128'(1'b0));
      check("single_cnt", 128'(f_cnt), 128'({32'd1, 32'd1, 32'd0}));

      // round-robin: every channel requests continuously with 2-beat packets
      do_reset;
      req = 3'b111;
      tvalid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         tick;
         for (int c = 0; c < N; c++) beat(c, 1'b1, 1'b0, 64'(c*256 + k*16));
         #1 check("rr_gch", 128'(r_gch), 128'(k % 3));
         check("rr_ack", 128'(r_ack), 128'(3'b001 << (k % 3)));
         check("rr_tready", 128'(r_tready), 128'(3'b001 << (k % 3)));
         check("rr_d0", 128'(r_tdata), 128'((k % 3)*256 + k*16));
         check("rr_tvalid", 128'(r_tvalid), 128'(1'b1));
         tick;
         for (int c = 0; c < N; c++) beat(c, 1'b1, 1'b1, 64'(c*256 + k*16 + 1));
         #1 check("rr_d1", 128'(r_tdata), 128'((k % 3)*256 + k*16 + 1));
         check("rr_last", 128'(r_tlast), 128'(1'b1));
         check("rr_keep", 128'(r_tkeep), 128'(8'h0F));
         check("rr_user", 128'(r_tuser), 128'(4'h1));
         tick;
         check("rr_bubble", 128'(r_busy), 128'(1'b0));
      end
      check("rr_cnt", 128'(r_cnt), 128'({32'd2, 32'd2, 32'd2}));
      check("rr_stall", 128'(r_stall), 128'(1'b0));

      // backpressure on a 4-beat ch0 packet while ch1 also presents data
      do_reset;
      req = 3'b001;
      beat(1, 1'b1, 1'b0, 64'hDEAD);
      tick;
      req = 3'b000;
      bi = 0;
      for (int c = 0; c < 6; c++) begin
         m_tready = pat[c];
         beat(0, 1'b1, bi == 3, 64'hB0 + 64'(bi));
         #1 check("bp_data", 128'(f_tdata), 128'(64'hB0 + 64'(bi)));
         check("bp_tready", 128'(f_tready), 128'({2'b00, pat[c]}));
         check("bp_tvalid", 128'(f_tvalid), 128'(1'b1));
         tick;
         if (pat[c]) bi++;
      end
      check("bp_busy", 128'(f_busy), 128'(1'b0));
      check("bp_cnt", 128'(f_cnt), 128'({32'd0, 32'd0, 32'd1}));
      beat(1, 1'b0, 1'b0, 64'h0);
      m_tready = 1'b1;

      // watchdog: 8 idle cycles inside a granted packet
      do_reset;
      req = 3'b001;
      beat(0, 1'b1, 1'b0, 64'hA0);
      tick;
      req = 3'b000;
      #1 check("wd_d0", 128'(f_tdata), 128'(64'hA0));
      tick;
      beat(0, 1'b0, 1'b0, 64'h0);
      for (int i = 1; i <= 8; i++) begin
         tick;
         check("wd_stall", 128'(f_stall), 128'(i == 8));
      end
      check("wd_grant_held", 128'(f_busy), 128'(1'b1));
      beat(0, 1'b1, 1'b1, 64'hA1);
      #1 check("wd_last", 128'(f_tlast), 128'(1'b1));
      tick;
      check("wd_done", 128'(f_busy), 128'(1'b0));
      check("wd_sticky", 128'(f_stall), 128'(1'b1));
      check("wd_cnt", 128'(f_cnt), 128'({32'd0, 32'd0, 32'd1}));

      // reset after beat 2 of a 4-beat ch2 packet
      req = 3'b100;
      beat(2, 1'b1, 1'b0, 64'hC0);
      tick;
      beat(2, 1'b1, 1'b0, 64'hC1);
      tick;
      pcie_rst = 1'b1;
      beat(2, 1'b1, 1'b0, 64'hC2);
      tick;
      pcie_rst = 1'b0;
      check("mr_ack", 128'(f_ack), 128'(3'b000));
      check("mr_tvalid", 128'(f_tvalid), 128'(1'b0));
      check("mr_cnt", 128'(f_cnt), 128'(96'h0));
      check("mr_stall", 128'(f_stall), 128'(1'b0));
      check("mr_gch", 128'(f_gch), 128'(2'd0));
      check("mr_rr_ack", 128'(r_ack), 128'(3'b000));
      req = 3'b111;
      tick;
      check("mr_fx_regrant", 128'(f_ack), 128'(3'b001));
      check("mr_rr_regrant", 128'(r_ack), 128'(3'b001));

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
